// File: rtl/cordic_pkg.sv
// cordic_pkg: FSM state encoding plus elaboration-time helpers that build the
// atan(2^-i)/pi table and the reciprocal CORDIC gain using integer math only.
package cordic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREROT,
    ST_ITER,
    ST_GAIN,
    ST_DONE
  } state_e;

  // round(2^28 / pi)
  localparam longint INV_PI_Q28 = 64'sd85445659;

  // atan(2^-i)/pi scaled by 2^(w-1), via the arctan series evaluated in Q34.
  function automatic longint atan_entry(input int i, input int w);
    longint s;
    longint term;
    int     sh;
    if (i == 0) return longint'(1) <<< (w - 3);
    s = 0;
    for (int k = 0; k < 24; k++) begin
      sh = i * (2 * k + 1);
      if (sh <= 34) begin
        term = (longint'(1) <<< (34 - sh)) / longint'(2 * k + 1);
        s    = (k % 2 == 0) ? s + term : s - term;
      end
    end
    s = s * INV_PI_Q28;
    return (s + (longint'(1) <<< (61 - (w - 1)))) >>> (62 - (w - 1));
  endfunction

  // round(2^(w-1) / K), K = prod sqrt(1 + 2^-2i); 1/K comes from an integer sqrt of 1/K^2.
  function automatic longint gain_comp(input int iters, input int w);
    longint k2;
    longint v;
    longint r;
    longint t;
    k2 = longint'(1) <<< 30;
    for (int i = 0; i < iters; i++) k2 = k2 + (k2 >>> (2 * i));
    v = ((longint'(1) <<< 60) / k2) <<< 30;
    r = 0;
    for (int b = 30; b >= 0; b--) begin
      t = r | (longint'(1) <<< b);
      if (t * t <= v) r = t;
    end
    return ((r <<< (w - 1)) + (longint'(1) <<< 29)) >>> 30;
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// cordic_atan_rom: constant atan(2^-i)/pi lookup, W-bit two's complement in units of pi.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 14,
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0]    idx,
  output logic signed [W-1:0] angle
);

  logic signed [W-1:0] rom [2**IDX_W];

  // Entries past the last iteration are padded so the index never leaves the table.
  for (genvar g = 0; g < 2**IDX_W; g++) begin : g_rom
    if (g < DEPTH) begin : g_used
      assign rom[g] = W'(atan_entry(g, W));
    end else begin : g_pad
      assign rom[g] = '0;
    end
  end

  assign angle = rom[idx];

endmodule

// File: rtl/cordic_vectoring_iter.sv
// cordic_vectoring_iter: iterative CORDIC vectoring unit, one micro-rotation per clock.
// Define CORDIC_GAIN_COMP_EN to add a GAIN state that divides out the CORDIC gain.
module cordic_vectoring_iter
  import cordic_pkg::*;
#(
  parameter int  N_INT          = 0,
  parameter int  N_FRAC         = -15,
  parameter int  ITERATIONS     = 14,
  parameter int  USE_SATURATION = 1,
  localparam int W              = N_INT - N_FRAC + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic signed [W-1:0] X_i,
  input  logic signed [W-1:0] Y_i,
  output logic                ready_o,
  output logic                valid_o,
  output logic signed [W+1:0] mag_o,
  output logic signed [W-1:0] angle_o
);

  localparam int XW    = W + 2;
  localparam int CNT_W = $clog2(W + 2);
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(ITERATIONS - 1);
  localparam logic [CNT_W-1:0] SH_MAX  = CNT_W'(W + 1);

  function automatic logic signed [XW-1:0] add_sat(input logic signed [XW-1:0] a,
                                                   input logic signed [XW-1:0] b,
                                                   input logic             sub);
    logic signed [XW:0] s;
    s = sub ? ({a[XW-1], a} - {b[XW-1], b}) : ({a[XW-1], a} + {b[XW-1], b});
    if (USE_SATURATION != 0 && s[XW] != s[XW-1])
      return s[XW] ? {1'b1, {(XW-1){1'b0}}} : {1'b0, {(XW-1){1'b1}}};
    return s[XW-1:0];
  endfunction

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [XW-1:0] GAIN_K = XW'(gain_comp(ITERATIONS, W));

  function automatic logic signed [XW-1:0] round_gain(input logic signed [XW-1:0] a);
    logic signed [2*XW-1:0] p;
    p = (2*XW)'(a) * (2*XW)'(GAIN_K);
    p = p + ((2*XW)'(1) <<< (W - 2));
    return XW'(p >>> (W - 1));
  endfunction
`endif

  state_e                state;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      sh;
  logic signed [XW-1:0]  x_q, y_q, xs, ys, x_nxt, y_nxt;
  logic signed [W-1:0]   z_q, z_nxt, atan;
  logic                  zero_q;

  cordic_atan_rom #(
    .W    (W),
    .DEPTH(ITERATIONS),
    .IDX_W(CNT_W)
  ) u_atan_rom (
    .idx  (cnt),
    .angle(atan)
  );

  // One micro-rotation; Z wraps modulo 2 naturally in W bits.
  always_comb begin
    sh = (cnt > SH_MAX) ? SH_MAX : cnt;
    xs = x_q >>> sh;
    ys = y_q >>> sh;
    if (y_q[XW-1]) begin
      x_nxt = add_sat(x_q, ys, 1'b1);
      y_nxt = add_sat(y_q, xs, 1'b0);
      z_nxt = z_q - atan;
    end else begin
      x_nxt = add_sat(x_q, ys, 1'b0);
      y_nxt = add_sat(y_q, xs, 1'b1);
      z_nxt = z_q + atan;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      cnt     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
      mag_o   <= '0;
      angle_o <= '0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            x_q     <= XW'(X_i);
            y_q     <= XW'(Y_i);
            zero_q  <= (X_i == '0) && (Y_i == '0);
            ready_o <= 1'b0;
            state   <= ST_PREROT;
          end
        end
        ST_PREROT: begin
          // Fold the left half-plane onto the right and start Z at -pi.
          if (x_q[XW-1]) begin
            x_q <= -x_q;
            y_q <= -y_q;
            z_q <= {1'b1, {(W-1){1'b0}}};
          end else begin
            z_q <= '0;
          end
          cnt   <= '0;
          state <= ST_ITER;
        end
        ST_ITER: begin
          x_q <= x_nxt;
          y_q <= y_nxt;
          z_q <= z_nxt;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_IT) begin
`ifdef CORDIC_GAIN_COMP_EN
            state <= ST_GAIN;
`else
            state <= ST_DONE;
`endif
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        ST_GAIN: begin
          x_q   <= round_gain(x_q);
          state <= ST_DONE;
        end
`endif
        ST_DONE: begin
          // A zero vector has no defined phase; report it as zero.
          valid_o <= 1'b1;
          mag_o   <= zero_q ? '0 : x_q;
          angle_o <= zero_q ? '0 : z_q;
          ready_o <= 1'b1;
          state   <= ST_IDLE;
        end
        default: begin
          ready_o <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vectoring_iter.sv
// tb_cordic_vectoring_iter: directed bench for cordic_vectoring_iter (default 16-bit format).
module tb_cordic_vectoring_iter;

  localparam int W = 16;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT       = 17;
  localparam int MAG_HALF  = 16384;
  localparam int MAG_DIAG  = 23170;
  localparam int MAG_FULL  = 46341;
  localparam int MAG_Q4    = 11585;
`else
  localparam int LAT       = 16;
  localparam int MAG_HALF  = 26980;
  localparam int MAG_DIAG  = 38156;
  localparam int MAG_FULL  = 76312;
  localparam int MAG_Q4    = 19078;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic signed [W-1:0] x_in, y_in;
  logic                ready, valid;
  logic signed [W+1:0] mag;
  logic signed [W-1:0] angle;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cordic_vectoring_iter #(
    .N_INT         (0),
    .N_FRAC        (-15),
    .ITERATIONS    (14),
    .USE_SATURATION(1)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .start_i(start),
    .X_i    (x_in),
    .Y_i    (y_in),
    .ready_o(ready),
    .valid_o(valid),
    .mag_o  (mag),
    .angle_o(angle)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int exp_v,
                            input int tol, input bit wrap16);
    int   d;
    logic ok;
    d = obs - exp_v;
    if (wrap16) d = int'($signed(16'(d)));
    ok = (d <= tol) && (d >= -tol);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d +/- %0d", tag, obs, obs, exp_v, tol);
    end
  endtask

  task automatic run_op(input string tag, input int xv, input int yv,
                        input int exp_ang, input int exp_mag, input int mag_tol);
    int n;
    bit seen;
    @(negedge clk);
    x_in  = 16'(xv);
    y_in  = 16'(yv);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq({tag, "_busy"}, ready, 0);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (valid === 1'b1) seen = 1'b1;
    end
    check_eq({tag, "_lat"}, n, LAT);
    check_near({tag, "_ang"}, int'(angle), exp_ang, 2, 1'b1);
    check_near({tag, "_mag"}, int'(mag), exp_mag, mag_tol, 1'b0);
    @(posedge clk);
    #1;
    check_eq({tag, "_pulse"}, valid, 0);
    check_eq({tag, "_idle"}, ready, 1);
  endtask

  initial begin
    int vcount, rcount, first_v, second_v, n, no_v;
    bit seen;

    rst   = 1'b1;
    start = 1'b0;
    x_in  = '0;
    y_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", ready, 1);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_mag", mag, 0);
    check_eq("rst_angle", angle, 0);
    rst = 1'b0;

    run_op("x_pos", 16384, 0, 0, MAG_HALF, 4);
    run_op("y_pos", 0, 16384, 16'h4000, MAG_HALF, 8);
    run_op("x_neg", -16384, 0, 16'h8000, MAG_HALF, 8);
    run_op("diag", 16384, 16384, 16'h2000, MAG_DIAG, 16);
    run_op("min_corner", -32768, -32768, 16'hA000, MAG_FULL, 16);
    run_op("quad4", 8192, -8192, 16'hE000, MAG_Q4, 16);
    run_op("zero", 0, 0, 0, 0, 0);
    run_op("diag2", 16384, 16384, 16'h2000, MAG_DIAG, 16);

    // start held high: one IDLE cycle between operations, none accepted mid-operation
    @(negedge clk);
    x_in     = 16384;
    y_in     = 16384;
    start    = 1'b1;
    vcount   = 0;
    rcount   = 0;
    first_v  = 0;
    second_v = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (valid === 1'b1) begin
        vcount++;
        if (vcount == 1) first_v = c;
        else if (vcount == 2) second_v = c;
        check_near("b2b_ang", int'(angle), 16'h2000, 2, 1'b1);
      end
      if (ready === 1'b1) rcount++;
    end
    start = 1'b0;
    check_eq("b2b_count", vcount, 2);
    check_eq("b2b_first", first_v, LAT + 1);
    check_eq("b2b_period", second_v - first_v, LAT + 1);
    check_eq("b2b_idle_cycles", rcount, 2);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (valid === 1'b1) seen = 1'b1;
    end
    check_eq("b2b_tail_seen", seen, 1);
    check_near("b2b_tail_ang", int'(angle), 16'h2000, 2, 1'b1);
    @(posedge clk);
    #1;
    check_eq("b2b_tail_idle", ready, 1);

    // reset on the 5th ITER cycle
    @(negedge clk);
    x_in  = 16384;
    y_in  = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("mid_rst_ready", ready, 1);
    check_eq("mid_rst_valid", valid, 0);
    check_eq("mid_rst_mag", mag, 0);
    check_eq("mid_rst_angle", angle, 0);
    no_v = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      if (valid !== 1'b0) no_v++;
    end
    check_eq("mid_rst_no_valid", no_v, 0);
    run_op("post_rst", 16384, 0, 0, MAG_HALF, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cordic_vectoring_iter.md
CORDIC_VECTORING_ITER -- requirements
Module: cordic_vectoring_iter

Interface
REQ-001 SHALL have parameter N_INT, default 0, integer bits of the input operand format.
REQ-002 SHALL have parameter N_FRAC, default -15, fractional LSB exponent; W = N_INT-N_FRAC+1.
REQ-003 SHALL have parameter ITERATIONS, default 14, micro-rotations per operation, range 1..W-1.
REQ-004 SHALL have parameter USE_SATURATION, default 1, saturating X/Y adds (1) or wrapping adds (0).
REQ-005 SHALL have ports: clk_i in 1 clock; rst_i in 1 reset, synchronous, active-high.
REQ-006 SHALL have ports: start_i in 1 launch request; X_i in W signed; Y_i in W signed.
REQ-007 SHALL have ports: ready_o out 1 idle; valid_o out 1 one-cycle result strobe.
REQ-008 SHALL have ports: mag_o out W+2 signed magnitude, same LSB weight as X_i; angle_o out W signed phase in units of pi, range [-1,1).

Function
REQ-009 SHALL implement FSM IDLE -> PREROT -> ITER -> (GAIN) -> DONE -> IDLE.
REQ-010 SHALL capture X_i/Y_i when start_i=1 in IDLE; ready_o=1 only in IDLE; start_i outside IDLE is ignored.
REQ-011 PREROT SHALL sign-extend X/Y to W+2 bits; if X<0: X=-X, Y=-Y, Z=100..0 (-pi); else Z=0.
REQ-012 ITER SHALL run i=0..ITERATIONS-1, one per cycle: d=+1 if Y<0 else -1; X-=d*(Y>>>i); Y+=d*(X>>>i); Z-=d*atan(2^-i)/pi (all from the pre-update values).
REQ-013 Z arithmetic SHALL always wrap modulo 2 (pi wraps to -pi); X/Y follow USE_SATURATION.
REQ-014 Shift amount SHALL be clamped to W+1.
REQ-015 DONE SHALL assert valid_o for exactly one cycle, then return to IDLE.
REQ-016 mag_o/angle_o SHALL update only in DONE and hold until the next DONE.
REQ-017 Latency: start_i accepted at edge k -> valid_o high in the cycle after edge k+ITERATIONS+2 (+1 with gain compensation).
REQ-018 X=Y=0 SHALL give mag_o=0 and angle_o=0.
REQ-019 start_i in the same cycle as DONE SHALL be ignored; accepted only from IDLE.

Reset
REQ-020 rst_i=1 at any clock edge SHALL force IDLE and zero all datapath registers, including mid-operation, with no pending valid_o.
REQ-021 After reset, outputs SHALL be mag_o=0, angle_o=0, valid_o=0, ready_o=1.

Configuration
REQ-022 Macro CORDIC_GAIN_COMP_EN defined: GAIN state SHALL multiply X by round(2^(W-1)/K), K=prod sqrt(1+2^-2i), rounding to nearest so mag_o ≈ sqrt(X^2+Y^2).
REQ-023 CORDIC_GAIN_COMP_EN undefined: no GAIN state; mag_o = K*sqrt(X^2+Y^2) raw.

Structure
REQ-024 Package cordic_pkg SHALL hold the FSM state enum, the atan(2^-i)/pi table generator and the gain constant function.
REQ-025 Sub-module cordic_atan_rom SHALL provide the index -> W-bit angle lookup.

Verification
Parameters N_INT=0, N_FRAC=-15, ITERATIONS=14, gain compensation off.
REQ-026 X=0x4000, Y=0 -> angle_o=0x0000 ±2, mag_o=0x6964 ±4 (0.5*K).
REQ-027 X=0, Y=0x4000 -> angle_o=0x4000 ±2; X=-0x4000, Y=0 -> angle_o=0x8000 ±2.
REQ-028 X=Y=0x4000 -> angle_o=0x2000 ±2; X=Y=-0x8000 -> angle_o=0xA000 ±2, no X/Y overflow.
REQ-029 start_i held high for 40 cycles -> operations back-to-back with one IDLE cycle each; no start accepted while ready_o=0.
REQ-030 rst_i pulsed on the 5th ITER cycle -> no valid_o, outputs 0, next start gives a correct result; repeat with CORDIC_GAIN_COMP_EN: X=0x4000, Y=0 -> mag_o=0x4000 ±4.
